// File: rtl/seg_scan_mux.sv
// seg_scan_mux: scans four display digits for the Basys 3 7-segment display.
// It drives the 4-bit code input of the downstream BCD-to-7-segment decoder
// and the active-low anodes.
//   clk, rst_n     : system clock, asynchronous active-low reset
//   load           : one-cycle strobe that captures digits_in / blink_mask_in
//   digits_in      : four codes, [3:0] = digit 0 (rightmost)
//   blink_mask_in  : bit i = 1 makes digit i blink
//   lz_en          : leading-zero suppression, used live
//   bcd            : code sent to the decoder (4'hF = blank)
//   an             : anodes, active-low
//   frame_start    : one-cycle pulse when scanning returns to digit 0
module seg_scan_mux #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] digits_in,
    input  logic [3:0]  blink_mask_in,
    input  logic        lz_en,
    output logic [3:0]  bcd,
    output logic [3:0]  an,
    output logic        frame_start
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
    localparam logic [FRM_W-1:0] FRM_MAX = FRM_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [FRM_W-1:0] frm_cnt_q, frm_cnt_d;
    logic             blink_on_q, blink_on_d;
    logic [15:0]      act_dig_q, act_dig_d;
    logic [3:0]       act_mask_q, act_mask_d;
    logic [15:0]      pend_dig_q, pend_dig_d;
    logic [3:0]       pend_mask_q, pend_mask_d;
    logic             pending_flag_q, pending_flag_d;
    logic [3:0]       an_q, an_d;
    logic [3:0]       bcd_q, bcd_d;
    logic             frame_start_q, frame_start_d;

    logic             tick_c;
    logic             wrap_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt_q     <= '0;
            idx_q          <= 2'd0;
            frm_cnt_q      <= '0;
            blink_on_q     <= 1'b1;
            act_dig_q      <= 16'h0000;
            act_mask_q     <= 4'b0000;
            pend_dig_q     <= 16'h0000;
            pend_mask_q    <= 4'b0000;
            pending_flag_q <= 1'b0;
            an_q           <= 4'b1110;
            bcd_q          <= 4'h0;
            frame_start_q  <= 1'b0;
        end else begin
            slot_cnt_q     <= slot_cnt_d;
            idx_q          <= idx_d;
            frm_cnt_q      <= frm_cnt_d;
            blink_on_q     <= blink_on_d;
            act_dig_q      <= act_dig_d;
            act_mask_q     <= act_mask_d;
            pend_dig_q     <= pend_dig_d;
            pend_mask_q    <= pend_mask_d;
            pending_flag_q <= pending_flag_d;
            an_q           <= an_d;
            bcd_q          <= bcd_d;
            frame_start_q  <= frame_start_d;
        end
    end

    // Slot timing, digit index and blink phase
    always_comb begin
        tick_c     = (slot_cnt_q == CNT_MAX);
        wrap_c     = tick_c && (idx_q == 2'd3);
        slot_cnt_d = tick_c ? '0 : slot_cnt_q + CNT_W'(1);
        idx_d      = tick_c ? idx_q + 2'd1 : idx_q;
        frm_cnt_d  = frm_cnt_q;
        blink_on_d = blink_on_q;
        if (wrap_c) begin
            if (frm_cnt_q == FRM_MAX) begin
                frm_cnt_d  = '0;
                blink_on_d = ~blink_on_q;
            end else begin
                frm_cnt_d  = frm_cnt_q + FRM_W'(1);
            end
        end
    end

    // Shadow buffer: loads land in pending, active only changes on a frame wrap
    always_comb begin
        pend_dig_d     = pend_dig_q;
        pend_mask_d    = pend_mask_q;
        pending_flag_d = pending_flag_q;
        act_dig_d      = act_dig_q;
        act_mask_d     = act_mask_q;
        if (load) begin
            pend_dig_d     = digits_in;
            pend_mask_d    = blink_mask_in;
            pending_flag_d = 1'b1;
        end
        if (wrap_c) begin
            // A load on the wrap cycle itself bypasses the pending stage
            if (load) begin
                act_dig_d      = digits_in;
                act_mask_d     = blink_mask_in;
                pending_flag_d = 1'b0;
            end else if (pending_flag_q) begin
                act_dig_d      = pend_dig_q;
                act_mask_d     = pend_mask_q;
                pending_flag_d = 1'b0;
            end
        end
    end

    // Outputs are computed for the next slot from next-state values so that a
    // committed frame and its new index appear on the same edge
    logic [3:0] zero_hi;
    logic [3:0] sel_dig;
    logic       blank_an;
    logic       suppress;

    always_comb begin
        zero_hi       = 4'b0000;
        zero_hi[3]    = (act_dig_d[15:12] == 4'h0);
        zero_hi[2]    = zero_hi[3] && (act_dig_d[11:8] == 4'h0);
        zero_hi[1]    = zero_hi[2] && (act_dig_d[7:4] == 4'h0);
        zero_hi[0]    = zero_hi[1] && (act_dig_d[3:0] == 4'h0);
        sel_dig       = act_dig_d[{idx_d, 2'b00} +: 4];
        blank_an      = !blink_on_d && act_mask_d[idx_d];
        suppress      = lz_en && (idx_d != 2'd0) && zero_hi[idx_d];
        bcd_d         = suppress ? 4'hF : sel_dig;
        an_d          = blank_an ? 4'b1111 : ~(4'b0001 << idx_d);
        frame_start_d = wrap_c;
    end

    assign bcd         = bcd_q;
    assign an          = an_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
module tb_seg_scan_mux;

    localparam int unsigned RDIV  = 4;
    localparam int unsigned BFRM  = 2;
    localparam int unsigned FRAME = RDIV * 4;
    localparam logic [15:0] AN_SCAN = 16'h7BDE;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [15:0] digits_in;
    logic [3:0]  blink_mask_in;
    logic        lz_en;
    logic [3:0]  bcd;
    logic [3:0]  an;
    logic        frame_start;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc_q;

    typedef struct {
        logic [15:0] digits;
        logic        lz;
        logic [15:0] exp_bcd;
    } vec_t;

    typedef struct {
        logic [15:0] bcd;
        logic [15:0] an;
    } exp_t;

    vec_t vecs [10];
    exp_t sb [$];

    seg_scan_mux #(
        .REFRESH_DIV  (RDIV),
        .BLINK_FRAMES (BFRM)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load          (load),
        .digits_in     (digits_in),
        .blink_mask_in (blink_mask_in),
        .lz_en         (lz_en),
        .bcd           (bcd),
        .an            (an),
        .frame_start   (frame_start)
    );

    always #5 clk = ~clk;

    // Posedges since reset release; a frame is FRAME cycles long
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc_q <= 0;
        else        cyc_q <= cyc_q + 1;
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] m);
        load          = 1'b1;
        digits_in     = d;
        blink_mask_in = m;
        @(negedge clk);
        load          = 1'b0;
    endtask

    task automatic wait_fs(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (frame_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s frame_start: got no pulse in 64 cycles, expected a pulse", name);
        end
    endtask

    // Called on the frame_start sample; checks all four slots of the frame
    task automatic check_frame(input string name);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL %s scoreboard: got empty queue, expected an entry", name);
            return;
        end
        e = sb.pop_front();
        for (int s = 0; s < 4; s++) begin
            if (s > 0) repeat (RDIV) @(negedge clk);
            chk($sformatf("%s slot%0d bcd", name, s), 16'(bcd), 16'(e.bcd[s*4 +: 4]));
            chk($sformatf("%s slot%0d an", name, s), 16'(an), 16'(e.an[s*4 +: 4]));
        end
    endtask

    initial begin
        logic [3:0] exp_an;
        logic       exp_on;

        vecs[0] = '{16'h1234, 1'b0, 16'h1234};
        vecs[1] = '{16'h0050, 1'b1, 16'hFF50};
        vecs[2] = '{16'h0000, 1'b1, 16'hFFF0};
        vecs[3] = '{16'h0000, 1'b0, 16'h0000};
        vecs[4] = '{16'hDE00, 1'b1, 16'hDE00};
        vecs[5] = '{16'h0A00, 1'b1, 16'hFA00};
        vecs[6] = '{16'h0007, 1'b1, 16'hFFF7};
        vecs[7] = '{16'hF00C, 1'b1, 16'hF00C};
        vecs[8] = '{16'h00B1, 1'b1, 16'hFFB1};
        vecs[9] = '{16'h1000, 1'b1, 16'h1000};

        rst_n         = 1'b0;
        load          = 1'b0;
        digits_in     = 16'h0;
        blink_mask_in = 4'h0;
        lz_en         = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        // Reset release: first tick RDIV cycles later, then the anode walk
        rst_n = 1'b1;
        #1;
        chk("reset an", 16'(an), 16'h000E);
        chk("reset bcd", 16'(bcd), 16'h0000);
        chk("reset frame_start", 16'(frame_start), 16'h0000);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            exp_an = ~(4'(4'b0001 << ((k / RDIV) % 4)));
            chk($sformatf("scan k%0d an", k), 16'(an), 16'(exp_an));
            chk($sformatf("scan k%0d bcd", k), 16'(bcd), 16'h0000);
            chk($sformatf("scan k%0d frame_start", k), 16'(frame_start), 16'(k == 16));
        end

        // Table vectors, each loaded mid-frame and shown from the next frame
        for (int i = 0; i < 10; i++) begin
            lz_en = vecs[i].lz;
            do_load(vecs[i].digits, 4'b0000);
            sb.push_back('{vecs[i].exp_bcd, AN_SCAN});
            if (i == 0) begin
                repeat (3) @(negedge clk);
                chk("pre-commit slot2 bcd", 16'(bcd), 16'h0000);
                repeat (RDIV) @(negedge clk);
                chk("pre-commit slot3 bcd", 16'(bcd), 16'h0000);
            end
            wait_fs($sformatf("vec%0d", i));
            check_frame($sformatf("vec%0d", i));
        end

        // Two loads in one frame: only the latest is ever shown
        lz_en = 1'b0;
        wait_fs("dbl sync");
        repeat (RDIV) @(negedge clk);
        do_load(16'h1111, 4'b0000);
        repeat (RDIV - 1) @(negedge clk);
        do_load(16'h9876, 4'b0000);
        repeat (RDIV - 1) @(negedge clk);
        chk("dbl old slot3 bcd", 16'(bcd), 16'h0001);
        sb.push_back('{16'h9876, AN_SCAN});
        sb.push_back('{16'h9876, AN_SCAN});
        wait_fs("dbl a");
        check_frame("dbl a");
        wait_fs("dbl b");
        check_frame("dbl b");

        // Load on the wrap cycle goes straight to the display
        repeat (FRAME - 1 - 3 * RDIV) @(negedge clk);
        do_load(16'hDE00, 4'b0000);
        chk("wrapload frame_start", 16'(frame_start), 16'h0001);
        sb.push_back('{16'hDE00, AN_SCAN});
        wait_fs("wrapload");
        chk("wrapload pending_flag", 16'(dut.pending_flag_q), 16'h0000);
        check_frame("wrapload");

        // Blink on digit 3 combined with leading-zero suppression
        lz_en = 1'b1;
        do_load(16'h0234, 4'b1000);
        wait_fs("blink commit");
        for (int f = 0; f < 5; f++) begin
            repeat (2 * RDIV) @(negedge clk);
            chk($sformatf("blink f%0d slot2 bcd", f), 16'(bcd), 16'h0002);
            chk($sformatf("blink f%0d slot2 an", f), 16'(an), 16'h000B);
            repeat (RDIV) @(negedge clk);
            exp_on = (((cyc_q / FRAME) / BFRM) % 2) == 0;
            chk($sformatf("blink f%0d slot3 an", f), 16'(an), exp_on ? 16'h0007 : 16'h000F);
            chk($sformatf("blink f%0d slot3 bcd", f), 16'(bcd), 16'h000F);
            wait_fs($sformatf("blink f%0d", f));
        end

        // Mid-frame reset with a pending load: immediate reset outputs, load lost
        lz_en = 1'b0;
        repeat (RDIV) @(negedge clk);
        do_load(16'h5555, 4'b1111);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async rst an", 16'(an), 16'h000E);
        chk("async rst bcd", 16'(bcd), 16'h0000);
        chk("async rst frame_start", 16'(frame_start), 16'h0000);
        chk("async rst pending_flag", 16'(dut.pending_flag_q), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back('{16'h0000, AN_SCAN});
        wait_fs("post-reset");
        check_frame("post-reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at %0t, expected bench to finish", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/seg_scan_mux.md
SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

Purpose: 4-digit time-multiplexed scanner for the Basys 3 display. Sits directly upstream of the BCD-to-7-segment decoder: drives its 4-bit code input and drives the anodes.

Interface
REQ-001 Parameter REFRESH_DIV, default 100000: clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range >= 2.
REQ-002 Parameter BLINK_FRAMES, default 125: full 4-digit frames per blink half-period (0.5 s at defaults); legal range >= 1.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 load  input  1  single-cycle strobe: capture digits_in and blink_mask_in.
REQ-006 digits_in  input  16  four 4-bit codes; [3:0] is digit 0 (rightmost), [15:12] is digit 3 (leftmost).
REQ-007 blink_mask_in  input  4  bit i=1 makes digit i blink.
REQ-008 lz_en  input  1  leading-zero suppression enable; sampled live, not via load.
REQ-009 bcd  output  4  code to decoder; 4'hF means blank.
REQ-010 an  output  4  anodes, active-low, at most one bit low.
REQ-011 frame_start  output  1  one-cycle pulse when scanning returns to digit 0.

Function
REQ-012 Slot counter: counts 0..REFRESH_DIV-1 and wraps; tick asserts for one cycle when count = REFRESH_DIV-1.
REQ-013 Digit index (2 bits): advances on tick; sequence 0,1,2,3,0.
REQ-014 Wrap event: tick while index = 3.
REQ-015 Shadow buffer: load captures digits_in and blink_mask_in into pending registers and sets pending_flag.
REQ-016 A second load while pending_flag is set overwrites the pending registers; the latest value wins.
REQ-017 Commit: on a wrap event with pending_flag set, the active registers take the pending values and pending_flag clears. Display updates are tear-free and change only at frame boundaries.
REQ-018 Load and wrap event in the same cycle: the active registers take that cycle's digits_in and blink_mask_in directly, and pending_flag ends cleared.
REQ-019 frame_start pulses high on the cycle after each wrap event, concurrent with an = 4'b1110.
REQ-020 Blink: frame counter counts 0..BLINK_FRAMES-1 on wrap events. blink_on toggles when the frame counter wraps.
REQ-021 an and bcd are registered and update on the same edge that advances the index, so the new slot's values appear together.
REQ-022 Slot i selection: an = ~(4'b0001 << i); bcd = active digit i.
REQ-023 Blink-off: if blink_on = 0 and active blink bit i = 1, then an = 4'b1111 for that slot; bcd is unchanged.
REQ-024 Leading-zero suppression: if lz_en = 1, i > 0, and active digit i and every higher digit equal 0, then bcd = 4'hF.
REQ-025 Digit 0 is never zero-suppressed.
REQ-026 Codes 4'hA–4'hF pass through unchanged. A, D and E are valid glyphs and count as nonzero for suppression.
REQ-027 When REQ-023 and REQ-024 both apply, blink blanking (an = 4'b1111) takes precedence.

Reset
REQ-028 While rst_n = 0, all state is forced immediately, independent of clk.
REQ-029 Reset state, counters: slot counter 0, index 0, frame counter 0.
REQ-030 Reset state, data registers: active digits 16'h0000, active blink mask 4'b0000, pending registers 0, pending_flag 0.
REQ-031 Reset state, status: blink_on 1.
REQ-032 Reset state, outputs: an = 4'b1110, bcd = 4'h0, frame_start = 0.
REQ-033 Reset asserted mid-frame discards any pending load.
REQ-034 After rst_n rises, the first tick occurs REFRESH_DIV cycles later.

Verification (REFRESH_DIV=4, BLINK_FRAMES=2)
REQ-035 Reset release: an = 1110 and bcd = 0 for 4 cycles; then an steps 1101, 1011, 0111, 1110 every 4 cycles; frame_start pulses with the return to 1110.
REQ-036 Load 16'h1234 at slot 1: display stays 0000 until the wrap. The next frame shows bcd 4,3,2,1 for slots 0–3.
REQ-037 Two loads in one frame (16'h1111, then 16'h9876): the next frame shows 6,7,8,9; 16'h1111 is never displayed.
REQ-038 Load coincident with the wrap cycle (16'hDE00): the immediately following frame shows 0,0,E,D; pending_flag is 0.
REQ-039 lz_en=1 with active 16'h0050: slot 3 and slot 2 show bcd F, slot 1 shows 5, slot 0 shows 0. With active 16'h0000, only slot 0 shows 0.
REQ-040 Blink mask 4'b1000 with 16'h1234: slot 3 has an = 0111 for 2 frames, then an = 1111 for 2 frames, repeating. rst_n pulsed low mid-sequence immediately returns an = 1110, bcd = 0.
